mem_responder: RTL
==================

# mem_responder

Single-port memory responder on the core's valid/ready request/response bus: it is the consumer of requests and the producer of responses that the fetch and load/store paths, through their skid buffers, initiate against. Accepts one request at a time with byte-masked writes and returns read data and an error flag after a fixed, parameterised latency. Holds a response stable under backpressure and sustains one transaction per LATENCY cycles when the initiator never stalls.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width; multiple of 8, power of two
- DEPTH, 1024, number of words; power of two
- LATENCY, 1, cycles from request accept to resp_valid; legal 1..4
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request this cycle
- req_addr  input  ADDR_WIDTH  byte address
- req_write  input  1  1 = write, 0 = read
- req_wdata  input  DATA_WIDTH  write data
- req_wmask  input  DATA_WIDTH/8  per-byte write enable
- resp_valid  output  1  response present
- resp_ready  input  1  initiator accepts response
- resp_rdata  output  DATA_WIDTH  read data; 0 for writes and errors
- resp_error  output  1  misaligned or out-of-range access

## Operation
- Accept = req_valid && req_ready; deliver = resp_valid && resp_ready.
- States: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On accept, go to RESP if LATENCY==1, else go to WAIT with the counter loaded to LATENCY-2.
  - WAIT: req_ready=0. Decrement the counter; at 0, go to RESP.
  - RESP: resp_valid=1. On deliver without accept, go to IDLE. On deliver with accept, start the new request exactly as from IDLE.
- req_ready = IDLE || (RESP && resp_ready). This combinational path from resp_ready is intentional.
- Word index = req_addr >> log2(DATA_WIDTH/8).
- resp_error=1 in either case:
  - low address bits are nonzero (misaligned);
  - index >= DEPTH, meaning any upper address bit above the index range is set.
- Error requests: no memory write; resp_rdata=0.
- Writes commit at the accept edge, only for bytes with the mask bit set. Mask 0 is a legal no-op write with resp_error=0. resp_rdata=0.
- Reads sample the array at the accept edge and capture the result into the response register.
  - A read accepted on the cycle after a write to the same word returns the new data.
- Memory contents are not reset and not initialised.

## Timing
- Reset values: resp_valid=0, resp_rdata=0, resp_error=0, state IDLE, counter 0. req_ready=1 immediately on reset assertion.
- Request accepted at edge N gives resp_valid high after edge N+LATENCY.
- Back-to-back throughput with resp_ready held high: one response every LATENCY cycles.
- While resp_valid && !resp_ready: resp_valid, resp_rdata and resp_error hold; req_ready=0.
- Reset asserted mid-transaction: the pending response is dropped. A write already accepted stays committed.
- resp_ready while resp_valid=0 is ignored. req_* inputs are ignored whenever req_ready=0.

## Structure
- Package mem_responder_pkg holds:
  - the state enum (IDLE, WAIT, RESP);
  - the legal LATENCY range constants (1..4);
  - a helper function for word-index and misalignment decode.
- Sub-module mem_responder_ram: synchronous-write, byte-enable word array with write-first read. It has no reset, so it can infer block RAM.
- Top level holds the FSM, latency counter and response register.
- Elaboration-time check rejects LATENCY outside 1..4 or a DATA_WIDTH that is not a power of two.

## Test plan
- Reset and idle: hold reset 3 cycles with req_valid=1, then release. Required: resp_valid=0 throughout reset, req_ready=1, no response produced while reset is held.
- Write/read, LATENCY=1: write 0xDEADBEEF to 0x10 with mask 0xF, then read 0x10. Required: write response rdata=0, error=0; read response 0xDEADBEEF, one cycle after each accept.
- Byte mask and back-to-back, LATENCY=3: write 0x11223344 to 0x20 with mask 0b0101, over a word previously holding 0xAAAAAAAA, then read 0x20 with resp_ready tied high. Required: read returns 0xAA22AA44; resp_valid edges 3 cycles after each accept.
- Errors:
  - read at 0x22 gives resp_error=1, rdata=0;
  - write at byte address DEPTH*4 gives resp_error=1 and word 0 stays unchanged.
- Backpressure: hold resp_ready=0 for 5 cycles with a read of 0x10 pending. Required: resp_valid, rdata and error stay constant; req_ready=0; a new req_valid is not accepted until the deliver cycle.
- Reset mid-WAIT, LATENCY=4: assert reset 2 cycles after accepting a write of 0x55 to 0x30. Required: no response after reset; a subsequent read of 0x30 returns 0x55.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared types and helpers for the single-port memory responder.
// Holds the FSM state encoding, legal latency range and address decode.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 4;

    // Word index of a byte address, given log2 of the bytes per word.
    function automatic logic [63:0] word_index(
        input logic [63:0] addr,
        input int unsigned lsb
    );
        return addr >> lsb;
    endfunction

    // Any byte-offset bit set means the access is not word aligned.
    function automatic logic misaligned(
        input logic [63:0] addr,
        input int unsigned lsb
    );
        logic [63:0] low;
        low = (64'd1 << lsb) - 64'd1;
        return |(addr & low);
    endfunction

endpackage

// File: rtl/mem_responder_ram.sv
// Byte-enable word array, synchronous write, write-first registered read.
// No reset so it can map onto block RAM.
module mem_responder_ram
    import mem_responder_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    localparam int IDX_W     = $clog2(DEPTH),
    localparam int BYTES     = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [IDX_W-1:0]      idx,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [BYTES-1:0]      be,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Per-byte write and write-first read capture on the same edge.
    always_ff @(posedge clk) begin
        for (int b = 0; b < BYTES; b++) begin
            if (we && be[b]) begin
                mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
            if (re) begin
                rdata[b*8 +: 8] <= (we && be[b]) ? wdata[b*8 +: 8]
                                                 : mem[idx][b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: one outstanding request, fixed response latency,
// response held stable until the initiator takes it.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic                    req_write,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wmask,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_error
);

    localparam int          BYTES    = DATA_WIDTH / 8;
    localparam int unsigned LSB      = $clog2(BYTES);
    localparam int          IDX_W    = $clog2(DEPTH);
    localparam logic [1:0]  CNT_LOAD = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

    if (LATENCY < LAT_MIN || LATENCY > LAT_MAX ||
        (DATA_WIDTH & (DATA_WIDTH - 1)) != 0 || (DATA_WIDTH % 8) != 0)
    begin : g_bad_params
        $error("mem_responder: illegal LATENCY or DATA_WIDTH");
    end

    state_t                state;
    state_t                state_nxt;
    logic [1:0]            cnt;
    logic [1:0]            cnt_nxt;
    logic                  accept;
    logic                  req_err;
    logic [IDX_W-1:0]      idx;
    logic                  resp_data_q;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign req_err = misaligned(64'(req_addr), LSB) ||
                     (word_index(64'(req_addr), LSB) >= 64'(DEPTH));
    assign idx       = IDX_W'(word_index(64'(req_addr), LSB));
    assign req_ready = (state == IDLE) || (state == RESP && resp_ready);
    assign accept    = req_valid && req_ready;
    assign resp_valid = (state == RESP);
    assign resp_rdata = resp_data_q ? ram_rdata : '0;

    mem_responder_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (accept && req_write && !req_err),
        .re    (accept && !req_write && !req_err),
        .idx   (idx),
        .wdata (req_wdata),
        .be    (req_wmask),
        .rdata (ram_rdata)
    );

    // State and latency counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: a new request may start from IDLE or from a delivering RESP.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (LATENCY == 1) ? RESP : WAIT;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            WAIT: begin
                if (cnt == 2'd0) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 2'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    if (accept) begin
                        state_nxt = (LATENCY == 1) ? RESP : WAIT;
                        cnt_nxt   = CNT_LOAD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 2'd0;
            end
        endcase
    end

    // Response attributes captured at accept; read data lives in the RAM register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_error  <= 1'b0;
            resp_data_q <= 1'b0;
        end else if (accept) begin
            resp_error  <= req_err;
            resp_data_q <= !req_write && !req_err;
        end
    end

endmodule
